// File: rtl/br_pc_ctrl_pkg.sv
// rtl/br_pc_ctrl_pkg.sv - shared funct3 codes and stage state for branch resolution
package brc_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } br_state_e;

endpackage

// File: rtl/br_pc_ctrl_if.sv
// rtl/br_pc_ctrl_if.sv - EX-stage branch request and PC/flush status bundle
// Counter outputs exist only when BR_STATS_EN is defined.
interface br_pc_ctrl_if #(
  parameter int unsigned XLEN = 32
);

  logic            i_valid;
  logic            i_stall;
  logic            i_is_br;
  logic            i_is_jmp;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_pc_ex;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] i_jmp_target;
  logic            i_br_less;
  logic            i_br_equal;
  logic            o_br_un;
  logic [XLEN-1:0] o_pc;
  logic            o_taken;
  logic            o_flush;
  logic            o_illegal;
  logic            o_misalign;
`ifdef BR_STATS_EN
  logic [31:0]     o_br_cnt;
  logic [31:0]     o_br_taken_cnt;
`endif

  modport master (
    output i_valid, i_stall, i_is_br, i_is_jmp, i_funct3, i_pc_ex, i_imm,
           i_jmp_target, i_br_less, i_br_equal,
    input  o_br_un, o_pc, o_taken, o_flush, o_illegal, o_misalign
`ifdef BR_STATS_EN
    , input o_br_cnt, o_br_taken_cnt
`endif
  );

  modport slave (
    input  i_valid, i_stall, i_is_br, i_is_jmp, i_funct3, i_pc_ex, i_imm,
           i_jmp_target, i_br_less, i_br_equal,
    output o_br_un, o_pc, o_taken, o_flush, o_illegal, o_misalign
`ifdef BR_STATS_EN
    , output o_br_cnt, o_br_taken_cnt
`endif
  );

endinterface

// File: rtl/br_pc_ctrl_cond_eval.sv
// rtl/br_pc_ctrl_cond_eval.sv - funct3 decode of comparator flags into a take decision
module br_cond_eval
  import brc_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       less_i,
  input  logic       equal_i,
  output logic       take_o,
  output logic       illegal_o,
  output logic       br_un_o
);

  assign br_un_o = ~funct3_i[1];

  always_comb begin
    take_o    = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:           take_o = equal_i;
      F3_BNE:           take_o = ~equal_i;
      F3_BLT, F3_BLTU:  take_o = less_i;
      F3_BGE, F3_BGEU:  take_o = ~less_i;
      default:          illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/br_pc_ctrl.sv
// rtl/br_pc_ctrl.sv - branch resolution, PC register and post-redirect flush sequencing
// Define BR_STATS_EN to add saturating branch and taken-redirect counters.
module br_pc_ctrl
  import brc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int unsigned     FLUSH_CYCLES = 1
) (
  input logic         i_clk,
  input logic         i_rst,
  br_pc_ctrl_if.slave bus
);

  localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  br_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, target;
  logic [2:0]      cnt_q, cnt_d;
  logic            taken_q, taken_d, illegal_q, illegal_d, misalign_q, misalign_d;
  logic            cond_take, cond_illegal, accept, is_br, redirect, target_bad;

  br_cond_eval u_cond (
    .funct3_i  (bus.i_funct3),
    .less_i    (bus.i_br_less),
    .equal_i   (bus.i_br_equal),
    .take_o    (cond_take),
    .illegal_o (cond_illegal),
    .br_un_o   (bus.o_br_un)
  );

  // A jump overrides a simultaneous branch flag.
  assign is_br      = bus.i_is_br & ~bus.i_is_jmp;
  assign accept     = bus.i_valid & ~bus.i_stall & (state_q == RUN);
  assign target     = bus.i_is_jmp ? bus.i_jmp_target : bus.i_pc_ex + bus.i_imm;
  assign redirect   = bus.i_is_jmp | (is_br & cond_take);
  assign target_bad = (target[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    taken_d    = 1'b0;
    illegal_d  = 1'b0;
    misalign_d = misalign_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          illegal_d = is_br & cond_illegal;
          if (redirect && target_bad) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else if (redirect) begin
            pc_d    = target;
            taken_d = 1'b1;
            cnt_d   = FLUSH_INIT;
            state_d = FLUSH;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end
      FLUSH: begin
        // Bubbles advance fetch unconditionally; stalls do not extend the flush.
        pc_d  = pc_q + PC_STEP;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      cnt_q      <= 3'd0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      taken_q    <= taken_d;
      illegal_q  <= illegal_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.o_pc       = pc_q;
  assign bus.o_taken    = taken_q;
  assign bus.o_flush    = (state_q == FLUSH);
  assign bus.o_illegal  = illegal_q;
  assign bus.o_misalign = misalign_q;

`ifdef BR_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d, tk_cnt_q, tk_cnt_d;

  assign br_cnt_d = (accept && (bus.i_is_br || bus.i_is_jmp) && !(&br_cnt_q))
                    ? br_cnt_q + 32'd1 : br_cnt_q;
  assign tk_cnt_d = (accept && redirect && !target_bad && !(&tk_cnt_q))
                    ? tk_cnt_q + 32'd1 : tk_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      br_cnt_q <= 32'd0;
      tk_cnt_q <= 32'd0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign bus.o_br_cnt       = br_cnt_q;
  assign bus.o_br_taken_cnt = tk_cnt_q;
`endif

endmodule

// File: tb/tb_br_pc_ctrl.sv
// tb/tb_br_pc_ctrl.sv - directed vector bench for br_pc_ctrl (FLUSH_CYCLES 1 and 3 instances)
module tb_br_pc_ctrl;

  typedef struct packed {
    logic        valid, stall, is_br, is_jmp;
    logic [2:0]  f3;
    logic [31:0] pc_ex, imm, jt;
    logic        less, eq;
    logic [31:0] e_pc;
    logic        e_taken, e_flush, e_ill, e_mis, e_un;
  } vec_t;

  logic clk = 1'b0;
  logic rst1, rst3;
  int   total = 0;
  int   bad   = 0;
  vec_t tv[20];

  always #5 clk = ~clk;

  br_pc_ctrl_if #(.XLEN(32)) bus1 ();
  br_pc_ctrl_if #(.XLEN(32)) bus3 ();

  br_pc_ctrl #(.XLEN(32), .RESET_PC(32'h0), .FLUSH_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .bus(bus1)
  );
  br_pc_ctrl #(.XLEN(32), .RESET_PC(32'h0), .FLUSH_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst(rst3), .bus(bus3)
  );

  function automatic vec_t mk(input logic v, s, b, j, input logic [2:0] f3,
                              input logic [31:0] pc_ex, imm, jt, input logic less, eq,
                              input logic [31:0] e_pc, input logic et, ef, ei, em, eu);
    vec_t r;
    r.valid = v; r.stall = s; r.is_br = b; r.is_jmp = j; r.f3 = f3;
    r.pc_ex = pc_ex; r.imm = imm; r.jt = jt; r.less = less; r.eq = eq;
    r.e_pc = e_pc; r.e_taken = et; r.e_flush = ef; r.e_ill = ei; r.e_mis = em; r.e_un = eu;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input vec_t v);
    bus1.i_valid = v.valid; bus1.i_stall = v.stall; bus1.i_is_br = v.is_br;
    bus1.i_is_jmp = v.is_jmp; bus1.i_funct3 = v.f3; bus1.i_pc_ex = v.pc_ex;
    bus1.i_imm = v.imm; bus1.i_jmp_target = v.jt; bus1.i_br_less = v.less;
    bus1.i_br_equal = v.eq;
  endtask

  task automatic d3(input logic v, s, b, input logic [2:0] f3,
                    input logic [31:0] pc_ex, imm, input logic less, eq);
    bus3.i_valid = v; bus3.i_stall = s; bus3.i_is_br = b; bus3.i_is_jmp = 1'b0;
    bus3.i_funct3 = f3; bus3.i_pc_ex = pc_ex; bus3.i_imm = imm;
    bus3.i_jmp_target = 32'h0; bus3.i_br_less = less; bus3.i_br_equal = eq;
  endtask

  task automatic chk3(input string nm, input logic [31:0] e_pc, input logic e_flush);
    chk({nm, " pc"}, bus3.o_pc, e_pc);
    chk({nm, " flush"}, {31'd0, bus3.o_flush}, {31'd0, e_flush});
  endtask

  initial begin
    //          v  s  br j  f3      pc_ex         imm           jt            ls eq  e_pc          tk fl il ms un
    tv[0]  = mk(1, 0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h4,        0, 0, 0, 0, 1);
    tv[1]  = mk(1, 0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h8,        0, 0, 0, 0, 1);
    tv[2]  = mk(1, 0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'hC,        0, 0, 0, 0, 1);
    tv[3]  = mk(1, 0, 1, 0, 3'b000, 32'h100,      32'h40,       32'h0,        0, 1, 32'h140,      1, 1, 0, 0, 1);
    tv[4]  = mk(1, 0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h144,      0, 0, 0, 0, 1);
    tv[5]  = mk(1, 0, 1, 0, 3'b001, 32'h100,      32'h40,       32'h0,        0, 1, 32'h148,      0, 0, 0, 0, 1);
    tv[6]  = mk(1, 1, 1, 0, 3'b000, 32'h100,      32'h40,       32'h0,        0, 1, 32'h148,      0, 0, 0, 0, 1);
    tv[7]  = mk(1, 0, 1, 0, 3'b110, 32'h300,      32'h10,       32'h0,        0, 0, 32'h14C,      0, 0, 0, 0, 0);
    tv[8]  = mk(1, 0, 1, 0, 3'b100, 32'h300,      32'h10,       32'h0,        1, 0, 32'h310,      1, 1, 0, 0, 1);
    tv[9]  = mk(0, 0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h314,      0, 0, 0, 0, 1);
    tv[10] = mk(1, 0, 1, 0, 3'b101, 32'h400,      32'hFFFFFFF8, 32'h0,        0, 0, 32'h3F8,      1, 1, 0, 0, 1);
    tv[11] = mk(0, 1, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h3FC,      0, 0, 0, 0, 1);
    tv[12] = mk(1, 0, 1, 0, 3'b111, 32'h400,      32'h8,        32'h0,        1, 0, 32'h400,      0, 0, 0, 0, 0);
    tv[13] = mk(1, 0, 1, 0, 3'b010, 32'h0,        32'h0,        32'h0,        1, 1, 32'h404,      0, 0, 1, 0, 0);
    tv[14] = mk(1, 0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h408,      0, 0, 0, 0, 1);
    tv[15] = mk(1, 0, 1, 1, 3'b000, 32'h0,        32'h0,        32'h800,      0, 0, 32'h800,      1, 1, 0, 0, 1);
    tv[16] = mk(1, 0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h804,      0, 0, 0, 0, 1);
    tv[17] = mk(1, 0, 1, 0, 3'b000, 32'hFFFFFF00, 32'h200,      32'h0,        0, 1, 32'h100,      1, 1, 0, 0, 1);
    tv[18] = mk(1, 0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h104,      0, 0, 0, 0, 1);
    tv[19] = mk(1, 0, 0, 1, 3'b000, 32'h0,        32'h0,        32'h202,      0, 0, 32'h104,      0, 0, 0, 1, 1);

    rst1 = 1'b1;
    rst3 = 1'b1;
    drive1(mk(0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    d3(0, 1, 0, 3'b000, 0, 0, 0, 0);
    repeat (2) tick();
    rst1 = 1'b0;
    rst3 = 1'b0;
    chk("reset pc", bus1.o_pc, 32'h0);
    chk("reset taken", {31'd0, bus1.o_taken}, 32'd0);
    chk("reset flush", {31'd0, bus1.o_flush}, 32'd0);
    chk("reset illegal", {31'd0, bus1.o_illegal}, 32'd0);
    chk("reset misalign", {31'd0, bus1.o_misalign}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      drive1(tv[i]);
      #1;
      chk($sformatf("v%0d br_un", i), {31'd0, bus1.o_br_un}, {31'd0, tv[i].e_un});
      tick();
      chk($sformatf("v%0d pc", i), bus1.o_pc, tv[i].e_pc);
      chk($sformatf("v%0d taken", i), {31'd0, bus1.o_taken}, {31'd0, tv[i].e_taken});
      chk($sformatf("v%0d flush", i), {31'd0, bus1.o_flush}, {31'd0, tv[i].e_flush});
      chk($sformatf("v%0d illegal", i), {31'd0, bus1.o_illegal}, {31'd0, tv[i].e_ill});
      chk($sformatf("v%0d misalign", i), {31'd0, bus1.o_misalign}, {31'd0, tv[i].e_mis});
    end

    for (int i = 0; i < 10; i++) begin
      drive1(mk(1, 0, 1, 0, 3'b000, 32'h100, 32'h40, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      tick();
      chk($sformatf("halt%0d pc", i), bus1.o_pc, 32'h104);
      chk($sformatf("halt%0d misalign", i), {31'd0, bus1.o_misalign}, 32'd1);
      chk($sformatf("halt%0d taken", i), {31'd0, bus1.o_taken}, 32'd0);
    end
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    chk("halt reset pc", bus1.o_pc, 32'h0);
    chk("halt reset misalign", {31'd0, bus1.o_misalign}, 32'd0);

    drive1(mk(1, 0, 0, 1, 3'b000, 0, 0, 32'hFFFFFFF8, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    chk("wrap jmp pc", bus1.o_pc, 32'hFFFFFFF8);
    drive1(mk(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    chk("wrap flush pc", bus1.o_pc, 32'hFFFFFFFC);
    chk("wrap flush done", {31'd0, bus1.o_flush}, 32'd0);
    tick();
    chk("wrap pc", bus1.o_pc, 32'h0);

    d3(1, 0, 1, 3'b000, 32'h100, 32'h40, 0, 1);
    tick();
    chk3("f3 taken", 32'h140, 1'b1);
    chk("f3 taken pulse", {31'd0, bus3.o_taken}, 32'd1);
    d3(0, 1, 0, 3'b000, 0, 0, 0, 0);
    tick();
    chk3("f3 c1", 32'h144, 1'b1);
    d3(1, 1, 1, 3'b000, 32'h100, 32'h40, 0, 1);
    tick();
    chk3("f3 c2", 32'h148, 1'b1);
    d3(1, 0, 1, 3'b000, 32'h100, 32'h40, 0, 1);
    tick();
    chk3("f3 c3", 32'h14C, 1'b0);
    d3(1, 0, 1, 3'b001, 32'h100, 32'h40, 0, 1);
    tick();
    chk3("f3 bne", 32'h150, 1'b0);
    d3(1, 0, 1, 3'b100, 32'h200, 32'h20, 1, 0);
    tick();
    chk3("f3 blt", 32'h220, 1'b1);
    d3(0, 0, 0, 3'b000, 0, 0, 0, 0);
    tick();
    chk3("f3 d1", 32'h224, 1'b1);
    tick();
    chk3("f3 d2", 32'h228, 1'b1);
    tick();
    chk3("f3 d3", 32'h22C, 1'b0);
    d3(1, 0, 1, 3'b111, 32'h0, 32'h0, 1, 0);
    tick();
    chk3("f3 bgeu", 32'h230, 1'b0);
    d3(1, 0, 1, 3'b010, 32'h0, 32'h0, 0, 0);
    tick();
    chk3("f3 illegal", 32'h234, 1'b0);
    chk("f3 illegal pulse", {31'd0, bus3.o_illegal}, 32'd1);
`ifdef BR_STATS_EN
    chk("stats br_cnt", bus3.o_br_cnt, 32'd5);
    chk("stats taken_cnt", bus3.o_br_taken_cnt, 32'd2);
`endif

    d3(1, 0, 1, 3'b000, 32'h100, 32'h40, 0, 1);
    tick();
    chk3("f3 mid taken", 32'h140, 1'b1);
    d3(0, 0, 0, 3'b000, 0, 0, 0, 0);
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    chk3("f3 mid reset", 32'h0, 1'b0);
    chk("f3 mid reset taken", {31'd0, bus3.o_taken}, 32'd0);
`ifdef BR_STATS_EN
    chk("stats reset", bus3.o_br_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
